i2si_rx_ctrl: RTL and testbench

Receive-side controller for the I2S input deserializer.
- Sequences the deserializer's enable (rf_i2si_en) from a software enable.
- Discards the first, partial frame after enable.
- Captures each completed stereo frame into a small FIFO on the transfer-complete pulse.
- Serves frames to a register/bus reader through a request/valid handshake, with overflow and interrupt reporting.

---
 rtl/i2si_pkg.sv | 14 +
 rtl/i2si_frame_fifo.sv | 62 ++++++
 rtl/i2si_rx_ctrl.sv | 101 ++++++++++
 tb/tb_i2si_rx_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/i2si_pkg.sv
// Shared types and defaults for the I2S receive controller.
package i2si_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/i2si_frame_fifo.sv
// Circular frame buffer with AW+1 bit pointers and a registered fill count.
module i2si_frame_fifo #(
    parameter int W  = 32,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [AW:0]   cnt,
    output logic          full,
    output logic          empty
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         wr;
    logic         rd;

    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);

    // A pop frees a slot in the same cycle, so a push into a full buffer
    // is accepted whenever a real pop accompanies it.
    assign rd    = pop & ~empty;
    assign wr    = push & (~full | rd);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + ONE;
            end
            if (rd) begin
                rptr <= rptr + ONE;
            end
            unique case ({wr, rd})
                2'b10:   cnt <= cnt + ONE;
                2'b01:   cnt <= cnt - ONE;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/i2si_rx_ctrl.sv
// I2S receive controller: enable sequencing, frame capture, read handshake,
// overflow and interrupt reporting.
module i2si_rx_ctrl
    import i2si_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int AW         = AW_DEF,
    parameter int IRQ_THRESH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sw_en,
    input  logic [DW-1:0]   i2si_lft,
    input  logic [DW-1:0]   i2si_rgt,
    input  logic            i2si_xfc,
    input  logic            rd_req,
    input  logic            ovf_clr,
    output logic            rf_i2si_en,
    output logic [2*DW-1:0] rd_data,
    output logic            rd_vld,
    output logic [AW:0]     fifo_cnt,
    output logic            busy,
    output logic            ovf,
    output logic            irq
);

    localparam logic [AW:0] THR = (AW+1)'(IRQ_THRESH);

    state_t          state;
    state_t          nstate;
    logic            push;
    logic            pop_ok;
    logic            ovf_set;
    logic            full;
    logic            empty;
    logic [2*DW-1:0] rdata;
    logic [AW:0]     cnt;

    assign push     = (state == RUN) & i2si_xfc;
    assign pop_ok   = rd_req & ~empty;
    assign ovf_set  = push & full & ~rd_req;
    assign fifo_cnt = cnt;
    assign busy     = (state != IDLE);

    i2si_frame_fifo #(
        .W  (2*DW),
        .AW (AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (rd_req),
        .wdata ({i2si_lft, i2si_rgt}),
        .rdata (rdata),
        .cnt   (cnt),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:  if (sw_en) nstate = ARM;
            ARM: begin
                if (!sw_en) begin
                    nstate = IDLE;
                end else if (i2si_xfc) begin
                    nstate = RUN;
                end
            end
            RUN:   if (!sw_en) nstate = DRAIN;
            DRAIN: if (cnt == '0) nstate = IDLE;
        endcase
    end

    // rf_i2si_en lags the state register by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            rf_i2si_en <= 1'b0;
            ovf        <= 1'b0;
            irq        <= 1'b0;
            rd_vld     <= 1'b0;
            rd_data    <= '0;
        end else begin
            state      <= nstate;
            rf_i2si_en <= (state == ARM) | (state == RUN);
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            irq    <= (cnt >= THR) | ovf;
            rd_vld <= pop_ok;
            if (pop_ok) begin
                rd_data <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_i2si_rx_ctrl.sv
// Directed self-checking bench for i2si_rx_ctrl.
module tb_i2si_rx_ctrl;

    logic        clk;
    logic        rst;
    logic        sw_en;
    logic [15:0] i2si_lft;
    logic [15:0] i2si_rgt;
    logic        i2si_xfc;
    logic        rd_req;
    logic        ovf_clr;
    logic        rf_i2si_en;
    logic [31:0] rd_data;
    logic        rd_vld;
    logic [2:0]  fifo_cnt;
    logic        busy;
    logic        ovf;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    i2si_rx_ctrl #(
        .DW         (16),
        .AW         (2),
        .IRQ_THRESH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_en      (sw_en),
        .i2si_lft   (i2si_lft),
        .i2si_rgt   (i2si_rgt),
        .i2si_xfc   (i2si_xfc),
        .rd_req     (rd_req),
        .ovf_clr    (ovf_clr),
        .rf_i2si_en (rf_i2si_en),
        .rd_data    (rd_data),
        .rd_vld     (rd_vld),
        .fifo_cnt   (fifo_cnt),
        .busy       (busy),
        .ovf        (ovf),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfc(input logic [15:0] l, input logic [15:0] r);
        i2si_lft = l;
        i2si_rgt = r;
        i2si_xfc = 1'b1;
        tick();
        i2si_xfc = 1'b0;
    endtask

    task automatic read(input string tag, input logic [31:0] exp);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check({tag, "_vld"}, {31'd0, rd_vld}, 32'd1);
        check({tag, "_data"}, rd_data, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"},   {31'd0, rf_i2si_en}, 32'd0);
        check({tag, "_data"}, rd_data, 32'd0);
        check({tag, "_vld"},  {31'd0, rd_vld}, 32'd0);
        check({tag, "_cnt"},  {29'd0, fifo_cnt}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_ovf"},  {31'd0, ovf}, 32'd0);
        check({tag, "_irq"},  {31'd0, irq}, 32'd0);
    endtask

    initial begin
        rst      = 1'b0;
        sw_en    = 1'b0;
        i2si_lft = '0;
        i2si_rgt = '0;
        i2si_xfc = 1'b0;
        rd_req   = 1'b0;
        ovf_clr  = 1'b0;
        repeat (3) tick();
        check_all_zero("rst");
        rst = 1'b1;
        tick();

        sw_en = 1'b1;
        tick();
        check("arm_busy", {31'd0, busy}, 32'd1);
        check("arm_en_lag", {31'd0, rf_i2si_en}, 32'd0);
        tick();
        check("arm_en", {31'd0, rf_i2si_en}, 32'd1);
        xfc(16'hAAAA, 16'h5555);
        check("drop_cnt", {29'd0, fifo_cnt}, 32'd0);
        xfc(16'h1234, 16'h5678);
        check("first_cnt", {29'd0, fifo_cnt}, 32'd1);
        read("first_rd", 32'h12345678);
        tick();
        check("vld_pulse", {31'd0, rd_vld}, 32'd0);

        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("empty_vld", {31'd0, rd_vld}, 32'd0);
        check("empty_data", rd_data, 32'h12345678);

        for (int i = 0; i < 5; i++) begin
            xfc(16'hA000 + 16'(i), 16'hB000 + 16'(i));
        end
        check("ovf_cnt", {29'd0, fifo_cnt}, 32'd4);
        check("ovf_set", {31'd0, ovf}, 32'd1);
        tick();
        check("ovf_irq", {31'd0, irq}, 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", {31'd0, ovf}, 32'd0);
        tick();
        check("clr_irq", {31'd0, irq}, 32'd1);

        for (int i = 5; i < 8; i++) begin
            i2si_lft = 16'hA000 + 16'(i);
            i2si_rgt = 16'hB000 + 16'(i);
            i2si_xfc = 1'b1;
            rd_req   = 1'b1;
            tick();
            i2si_xfc = 1'b0;
            rd_req   = 1'b0;
            check("pp_cnt", {29'd0, fifo_cnt}, 32'd4);
            check("pp_ovf", {31'd0, ovf}, 32'd0);
            check("pp_vld", {31'd0, rd_vld}, 32'd1);
            check("pp_data", rd_data, {16'hA000 + 16'(i - 5),
                                       16'hB000 + 16'(i - 5)});
        end
        read("wrap0", 32'hA003B003);
        read("wrap1", 32'hA005B005);
        read("wrap2", 32'hA006B006);
        read("wrap3", 32'hA007B007);
        check("wrap_cnt", {29'd0, fifo_cnt}, 32'd0);

        for (int i = 0; i < 3; i++) begin
            xfc(16'hC000 + 16'(i), 16'hD000 + 16'(i));
        end
        check("dr_cnt3", {29'd0, fifo_cnt}, 32'd3);
        sw_en = 1'b0;
        tick();
        check("dr_busy", {31'd0, busy}, 32'd1);
        tick();
        check("dr_en", {31'd0, rf_i2si_en}, 32'd0);
        xfc(16'hEEEE, 16'hFFFF);
        check("dr_ign", {29'd0, fifo_cnt}, 32'd3);
        read("dr0", 32'hC000D000);
        read("dr1", 32'hC001D001);
        read("dr2", 32'hC002D002);
        tick();
        tick();
        check("dr_idle", {31'd0, busy}, 32'd0);
        check("dr_irq", {31'd0, irq}, 32'd0);
        check("dr_st", {30'd0, dut.state}, 32'd0);

        sw_en = 1'b1;
        tick();
        xfc(16'h0101, 16'h0202);
        xfc(16'h1111, 16'h2222);
        xfc(16'h3333, 16'h4444);
        tick();
        check("mr_cnt", {29'd0, fifo_cnt}, 32'd2);
        check("mr_irq", {31'd0, irq}, 32'd1);
        #2;
        rst   = 1'b0;
        sw_en = 1'b0;
        #1;
        check_all_zero("mr_async");
        #3;
        rst = 1'b1;
        tick();
        check("mr_cnt0", {29'd0, fifo_cnt}, 32'd0);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_st", {30'd0, dut.state}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
